// File: rtl/alu_seq.sv
// Sequential handshaked ALU: single-cycle add/sub/logic ops, iterative shift-add multiply
// and restoring divide, one operation in flight, registered result and status flags.
module alu_seq #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            oc,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] f,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_v,
    output logic                  flag_dz
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    is_div_r;
    logic [CW-1:0]           cnt_r;
    logic [DATA_WIDTH-1:0]   hi_r;   // product high half / partial remainder
    logic [DATA_WIDTH-1:0]   lo_r;   // multiplier bits / dividend shifting into quotient
    logic [DATA_WIDTH-1:0]   opd_r;  // multiplicand / divisor

    logic [DATA_WIDTH:0]     sum_s;
    logic [DATA_WIDTH:0]     diff_s;
    logic [DATA_WIDTH-1:0]   res_s;
    logic                    c_s;
    logic                    v_s;
    logic                    dz_s;
    logic                    iter_s;
    logic [DATA_WIDTH:0]     mul_sum_s;
    logic [DATA_WIDTH:0]     rem_shift_s;
    logic [DATA_WIDTH-1:0]   step_hi_s;
    logic [DATA_WIDTH-1:0]   step_lo_s;

    // Single-cycle result and flags, computed directly from the live operands
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} - {1'b0, b};
        res_s  = {DATA_WIDTH{1'b0}};
        c_s    = 1'b0;
        v_s    = 1'b0;
        dz_s   = 1'b0;
        iter_s = 1'b0;
        case (oc)
            OC_ADD: begin
                res_s = sum_s[DATA_WIDTH-1:0];
                c_s   = sum_s[DATA_WIDTH];
                v_s   = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (sum_s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OC_SUB: begin
                res_s = diff_s[DATA_WIDTH-1:0];
                c_s   = diff_s[DATA_WIDTH];
                v_s   = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (diff_s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OC_MUL: iter_s = 1'b1;
            OC_DIV: begin
                if (b == {DATA_WIDTH{1'b0}}) begin
                    dz_s = 1'b1;
                end else begin
                    iter_s = 1'b1;
                end
            end
            OC_NOT:  res_s = ~a;
            OC_XOR:  res_s = a ^ b;
            OC_OR:   res_s = a | b;
            OC_AND:  res_s = a & b;
            default: res_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : {(DATA_WIDTH + 1){1'b0}});
        rem_shift_s = {hi_r, lo_r[DATA_WIDTH-1]};
        if (is_div_r) begin
            if (rem_shift_s >= {1'b0, opd_r}) begin
                // Difference is below the divisor, so the low bits hold it exactly
                step_hi_s = rem_shift_s[DATA_WIDTH-1:0] - opd_r;
                step_lo_s = {lo_r[DATA_WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = rem_shift_s[DATA_WIDTH-1:0];
                step_lo_s = {lo_r[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[DATA_WIDTH:1];
            step_lo_s = {mul_sum_s[0], lo_r[DATA_WIDTH-1:1]};
        end
    end

    // Control FSM with registered handshake, result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            f         <= {DATA_WIDTH{1'b0}};
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_dz   <= 1'b0;
            is_div_r  <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            hi_r      <= {DATA_WIDTH{1'b0}};
            lo_r      <= {DATA_WIDTH{1'b0}};
            opd_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (iter_s) begin
                            state_r  <= BUSY;
                            is_div_r <= (oc == OC_DIV);
                            cnt_r    <= {CW{1'b0}};
                            hi_r     <= {DATA_WIDTH{1'b0}};
                            lo_r     <= (oc == OC_DIV) ? a : b;
                            opd_r    <= (oc == OC_DIV) ? b : a;
                        end else begin
                            state_r   <= DONE;
                            out_valid <= 1'b1;
                            f         <= res_s;
                            flag_z    <= (res_s == {DATA_WIDTH{1'b0}});
                            flag_c    <= c_s;
                            flag_v    <= v_s;
                            flag_dz   <= dz_s;
                        end
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    hi_r  <= step_hi_s;
                    lo_r  <= step_lo_s;
                    if (cnt_r == CNT_LAST) begin
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        f         <= step_lo_s;
                        flag_z    <= (step_lo_s == {DATA_WIDTH{1'b0}});
                        flag_c    <= !is_div_r && (step_hi_s != {DATA_WIDTH{1'b0}});
                        flag_v    <= 1'b0;
                        flag_dz   <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (DATA_WIDTH=16): directed cases plus random operations checked against
// an arithmetic reference model, including latency, backpressure and mid-operation reset.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  oc;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic        flag_dz;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .oc(oc), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_dz(flag_dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input logic [15:0] x);
        return (int'(x) >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    // Reference: returns {dz, v, c, z, f} from plain integer arithmetic
    function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        longint r;
        int     s;
        logic [15:0] rf;
        logic rc, rv, rdz;
        rc = 1'b0; rv = 1'b0; rdz = 1'b0; rf = 16'h0000;
        case (op)
            3'd0: begin
                r = longint'(x) + longint'(y); rf = 16'(r); rc = (r > 65535);
                s = sgn(x) + sgn(y); rv = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                r = longint'(x) - longint'(y); rf = 16'(r); rc = (x < y);
                s = sgn(x) - sgn(y); rv = (s > 32767) || (s < -32768);
            end
            3'd2: begin
                r = longint'(x) * longint'(y); rf = 16'(r); rc = (r > 65535);
            end
            3'd3: begin
                if (y == 16'h0000) rdz = 1'b1;
                else rf = x / y;
            end
            3'd4: rf = ~x;
            3'd5: rf = x ^ y;
            3'd6: rf = x | y;
            default: rf = x & y;
        endcase
        return {rdz, rv, rc, (rf == 16'h0000), rf};
    endfunction

    // Issue one op, scramble inputs while it runs, check latency/result, hold out_ready low 'hold' cycles
    task automatic run_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y, input int hold);
        logic [19:0] exp;
        int lat;
        int k;
        exp = model(op, x, y);
        lat = (op == 3'd2 || (op == 3'd3 && y != 16'h0000)) ? 17 : 1;
        out_ready = (hold == 0);
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        in_valid = 1'b1; oc = op; a = x; b = y;
        @(posedge clk); #1;
        k = 1;
        while (!out_valid && k < 40) begin
            in_valid = 1'b1; oc = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        check($sformatf("latency_oc%0d", op), 32'(k), 32'(lat));
        check($sformatf("f_oc%0d_%0h_%0h", op, x, y), 32'(f), 32'(exp[15:0]));
        check($sformatf("flags_oc%0d_%0h_%0h", op, x, y), {28'd0, flag_dz, flag_v, flag_c, flag_z}, {28'd0, exp[19:16]});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_f_stable", 32'(f), 32'(exp[15:0]));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_return", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] edge_vals [4];
        edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF; edge_vals[2] = 16'h8000; edge_vals[3] = 16'h7FFF;

        rst = 1'b1; in_valid = 1'b0; oc = 3'd0; a = 16'h0000; b = 16'h0000; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {27'd0, in_ready, out_valid, flag_z, flag_c, flag_v}, 32'h10);
        check("reset_f_dz", {15'd0, flag_dz, f}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 16'hFFFF, 16'h0001, 0);
        run_op(3'd0, 16'h7FFF, 16'h0001, 0);
        run_op(3'd1, 16'h0003, 16'h0005, 0);
        run_op(3'd1, 16'h8000, 16'h0001, 0);
        run_op(3'd2, 16'd300, 16'd300, 0);
        run_op(3'd2, 16'd7, 16'd6, 0);
        run_op(3'd3, 16'd1000, 16'd7, 0);
        run_op(3'd3, 16'd5, 16'd0, 0);
        run_op(3'd5, 16'hF0F0, 16'h0FF0, 10);
        run_op(3'd4, 16'h00FF, 16'h0000, 2);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            x  = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            y  = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            if (op == 3'd3 && $urandom_range(0, 5) == 0) y = 16'h0000;
            run_op(op, x, y, $urandom_range(0, 3));
        end

        // Abort a multiply five cycles in with reset
        in_valid = 1'b1; oc = 3'd2; a = 16'd300; b = 16'd300;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_handshake", {30'd0, in_ready, out_valid}, 32'd2);
        check("abort_f_flags", {12'd0, flag_dz, flag_v, flag_c, flag_z, f}, 32'h0);
        repeat (20) begin
            @(posedge clk); #1;
            check("abort_no_stale_valid", 32'(out_valid), 32'd0);
        end
        run_op(3'd0, 16'd2, 16'd2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
